// File: rtl/if_prefetch_if.sv
// if_prefetch_if: bundles the fetch unit's memory bus, the downstream
// instruction stream and the redirect request.
//   master modport (the prefetcher):
//     in : jump, jump_addr, ram_ready, ram_data, out_ready
//     out: ram_read, ram_addr, out_valid, pc_o, inst_o, stall_if
//   slave modport (memory / pipeline side): the same signals, reversed.
interface if_prefetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  logic                  jump;
  logic [ADDR_WIDTH-1:0] jump_addr;
  logic                  ram_read;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_ready;
  logic [INST_WIDTH-1:0] ram_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] pc_o;
  logic [INST_WIDTH-1:0] inst_o;
  logic                  stall_if;

  modport master (
    input  jump, jump_addr, ram_ready, ram_data, out_ready,
    output ram_read, ram_addr, out_valid, pc_o, inst_o, stall_if
  );

  modport slave (
    output jump, jump_addr, ram_ready, ram_data, out_ready,
    input  ram_read, ram_addr, out_valid, pc_o, inst_o, stall_if
  );
endinterface

// File: rtl/if_prefetch.sv
// if_prefetch: instruction prefetcher. Issues one read at a time to an
// instruction memory, collects {pc, inst} pairs in a DEPTH-entry queue and
// presents the queue head downstream. A jump flushes the queue and redirects
// fetching; a read already in flight when the jump arrives is completed and
// its data thrown away.
// Ports:
//   clk   - clock, all state changes on the rising edge
//   reset - synchronous active-high reset
//   bus   - if_prefetch_if.master (memory bus, output stream, redirect)
module if_prefetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input logic           clk,
  input logic           reset,
  if_prefetch_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] pc_mem_q   [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem_q [DEPTH];

  logic                  head_valid;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic [CNT_W-1:0]      count_after_push;

  assign head_valid = (count_q != '0);
  assign next_pc    = fetch_pc_q + ADDR_WIDTH'(4);

  always_comb begin
    state_d          = state_q;
    fetch_pc_d       = fetch_pc_q;
    ram_addr_d       = ram_addr_q;
    count_d          = count_q;
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    push             = 1'b0;
    pop              = 1'b0;
    count_after_push = count_q;

    if (bus.jump) begin
      // Flush wins over any same-cycle push or pop.
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = bus.jump_addr;
      if (state_q == IDLE || bus.ram_ready) begin
        state_d    = REQ;
        ram_addr_d = bus.jump_addr;
      end else begin
        // The in-flight read must still complete on the old address.
        state_d = DROP;
      end
    end else begin
      pop = head_valid && bus.out_ready;
      // Count after a push this cycle; REQ is never entered with a full queue,
      // so this cannot overflow.
      count_after_push = count_q + CNT_W'(1) - CNT_W'(pop);
      unique case (state_q)
        IDLE: begin
          if (count_q < FULL) begin
            state_d    = REQ;
            ram_addr_d = fetch_pc_q;
          end
        end
        REQ: begin
          if (bus.ram_ready) begin
            push       = 1'b1;
            fetch_pc_d = next_pc;
            if (count_after_push < FULL) begin
              state_d    = REQ;
              ram_addr_d = next_pc;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DROP: begin
          if (bus.ram_ready) begin
            state_d    = REQ;
            ram_addr_d = fetch_pc_q;
          end
        end
        default: state_d = IDLE;
      endcase
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      ram_addr_q <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      ram_addr_q <= ram_addr_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]   <= ram_addr_q;
        inst_mem_q[wr_ptr_q] <= bus.ram_data;
      end
    end
  end

  assign bus.ram_read  = (state_q != IDLE);
  assign bus.ram_addr  = ram_addr_q;
  assign bus.out_valid = head_valid;
  assign bus.pc_o      = head_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign bus.inst_o    = head_valid ? inst_mem_q[rd_ptr_q] : '0;
  assign bus.stall_if  = !head_valid;

endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: drives if_prefetch through directed scenarios (streaming,
// full queue, jump with a read in flight, jump colliding with ready and pop,
// reset mid-read, address wrap) followed by randomized traffic. A
// transaction-level model (one outstanding read, a drop flag, a queue of
// {pc, inst}) predicts every output each cycle.
module tb_if_prefetch;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;

  if_prefetch_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus ();

  if_prefetch #(
    .ADDR_WIDTH(32),
    .INST_WIDTH(32),
    .DEPTH     (DEPTH),
    .RESET_PC  (32'h0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int ready_hits = 0;

  // Reference model state.
  logic [31:0] m_pc_q[$];
  logic [31:0] m_inst_q[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_addr;
  logic        m_out;
  logic        m_drop;
  int          m_wait;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic checkOutput();
    check("ram_read", 32'(bus.ram_read), 32'(m_out));
    if (m_out) check("ram_addr", bus.ram_addr, m_addr);
    check("out_valid", 32'(bus.out_valid), 32'(m_pc_q.size() > 0));
    check("pc_o", bus.pc_o, (m_pc_q.size() > 0) ? m_pc_q[0] : 32'h0);
    check("inst_o", bus.inst_o, (m_inst_q.size() > 0) ? m_inst_q[0] : 32'h0);
    check("stall_if", 32'(bus.stall_if), 32'(m_pc_q.size() == 0));
  endtask

  // Memory responder: answers each read after `delay` idle cycles.
  task automatic nextReady(input int delay, output logic r);
    r = 1'b0;
    if (!m_out) m_wait = delay;
    else if (m_wait == 0) begin
      r = 1'b1;
      m_wait = delay;
    end else m_wait = m_wait - 1;
  endtask

  // Called at a falling edge: drive one cycle of inputs, advance the model,
  // move to the next falling edge and compare.
  task automatic applyStimulus(input logic rst, input logic j, input logic [31:0] ja,
                               input logic ordy, input logic rrdy_req);
    logic        rrdy;
    logic [31:0] data;
    logic        pop;
    logic        room;
    rrdy = rrdy_req && m_out;
    data = rrdy ? mem_word(m_addr) : $urandom;
    if (bus.ram_read && rrdy) ready_hits = ready_hits + 1;
    reset         = rst;
    bus.jump      = j;
    bus.jump_addr = ja;
    bus.out_ready = ordy;
    bus.ram_ready = rrdy;
    bus.ram_data  = data;

    if (rst) begin
      m_pc_q.delete();
      m_inst_q.delete();
      m_fetch_pc = 32'h0;
      m_addr     = 32'h0;
      m_out      = 1'b0;
      m_drop     = 1'b0;
      m_wait     = 0;
    end else if (j) begin
      m_pc_q.delete();
      m_inst_q.delete();
      m_fetch_pc = ja;
      if (m_out && !rrdy) m_drop = 1'b1;
      else begin
        m_out  = 1'b1;
        m_drop = 1'b0;
        m_addr = ja;
      end
    end else begin
      pop  = (m_pc_q.size() > 0) && ordy;
      room = m_pc_q.size() < DEPTH;
      if (pop) begin
        void'(m_pc_q.pop_front());
        void'(m_inst_q.pop_front());
      end
      if (!m_out) begin
        if (room) begin
          m_out  = 1'b1;
          m_addr = m_fetch_pc;
        end
      end else if (rrdy) begin
        if (m_drop) begin
          m_drop = 1'b0;
          m_addr = m_fetch_pc;
        end else begin
          m_pc_q.push_back(m_addr);
          m_inst_q.push_back(data);
          m_fetch_pc = m_fetch_pc + 32'd4;
          if (m_pc_q.size() < DEPTH) m_addr = m_fetch_pc;
          else m_out = 1'b0;
        end
      end
    end

    @(negedge clk);
    checkOutput();
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check("rst_ram_read", 32'(bus.ram_read), 32'h0);
    check("rst_ram_addr", bus.ram_addr, 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_pc_o", bus.pc_o, 32'h0);
    check("rst_inst_o", bus.inst_o, 32'h0);
    check("rst_stall_if", 32'(bus.stall_if), 32'h1);
  endtask

  initial begin
    logic r;
    logic j;
    logic rst;
    logic [31:0] ja;
    reset = 1'b1;
    bus.jump = 1'b0;
    bus.jump_addr = '0;
    bus.out_ready = 1'b0;
    bus.ram_ready = 1'b0;
    bus.ram_data  = '0;
    m_pc_q.delete();
    m_inst_q.delete();
    m_fetch_pc = 32'h0;
    m_addr = 32'h0;
    m_out = 1'b0;
    m_drop = 1'b0;
    m_wait = 0;
    @(negedge clk);

    // Sequential streaming, memory answers on the first request cycle.
    $display("[TB] sequential fetch");
    doReset();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("first_req_read", 32'(bus.ram_read), 32'h1);
    check("first_req_addr", bus.ram_addr, 32'h0);
    for (int k = 0; k < 8 && !bus.out_valid; k++) begin
      nextReady(0, r);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, r);
    end
    check("seq_start", 32'(bus.out_valid), 32'h1);
    for (int i = 0; i < 4; i++) begin
      check("seq_pc", bus.pc_o, 32'(i * 4));
      check("seq_inst", bus.inst_o, mem_word(32'(i * 4)));
      check("seq_stall", 32'(bus.stall_if), 32'h0);
      nextReady(0, r);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, r);
    end

    // Queue fills with nobody draining it.
    $display("[TB] queue full");
    doReset();
    ready_hits = 0;
    for (int k = 0; k < 10; k++) begin
      nextReady(0, r);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, r);
    end
    check("full_pushes", 32'(ready_hits), 32'd4);
    check("full_read", 32'(bus.ram_read), 32'h0);
    check("full_head", bus.pc_o, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("full_pop_head", bus.pc_o, 32'h4);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("full_refill_read", 32'(bus.ram_read), 32'h1);
    check("full_refill_addr", bus.ram_addr, 32'h10);

    // Jump while a read is outstanding; memory answers late.
    $display("[TB] jump with read in flight");
    doReset();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
    check("drop_read", 32'(bus.ram_read), 32'h1);
    check("drop_addr0", bus.ram_addr, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("drop_addr1", bus.ram_addr, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("drop_addr2", bus.ram_addr, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("drop_new_addr", bus.ram_addr, 32'h100);
    check("drop_no_push", 32'(bus.out_valid), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("jump_head_pc", bus.pc_o, 32'h100);
    check("jump_head_inst", bus.inst_o, mem_word(32'h100));

    // Jump in the same cycle as ram_ready and a pop.
    $display("[TB] jump with ready and pop");
    applyStimulus(1'b0, 1'b1, 32'h200, 1'b1, 1'b1);
    check("jrp_valid", 32'(bus.out_valid), 32'h0);
    check("jrp_addr", bus.ram_addr, 32'h200);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("jrp_still_empty", 32'(bus.out_valid), 32'h0);

    // Reset while a read is outstanding, memory answering during reset.
    $display("[TB] reset mid-request");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    check("mid_rst_read", 32'(bus.ram_read), 32'h0);
    check("mid_rst_addr", bus.ram_addr, 32'h0);
    check("mid_rst_stall", 32'(bus.stall_if), 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("restart_read", 32'(bus.ram_read), 32'h1);
    check("restart_addr", bus.ram_addr, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("restart_head", bus.pc_o, 32'h0);

    // Fetch address wraps past the top of memory.
    $display("[TB] pc wrap");
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("wrap_head0", bus.pc_o, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("wrap_head1", bus.pc_o, 32'h0);

    // Randomized traffic against the model.
    $display("[TB] random traffic");
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      j   = ($urandom_range(0, 19) == 0);
      ja  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) ja = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
      nextReady(int'($urandom_range(0, 3)), r);
      applyStimulus(rst, j, ja, ($urandom_range(0, 9) < 6), r);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, memory address width.
REQ-002 SHALL have parameter INST_WIDTH, default 32, instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, prefetch queue entries; a power of two, at least 2.
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-005 SHALL have port clk, in, 1, sole clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, in, 1, synchronous active-high reset.
REQ-007 SHALL have port jump, in, 1, redirect request, qualified each cycle.
REQ-008 SHALL have port jump_addr, in, ADDR_WIDTH, redirect target.
REQ-009 SHALL have port ram_read, out, 1, memory read request.
REQ-010 SHALL have port ram_addr, out, ADDR_WIDTH, memory read address.
REQ-011 SHALL have port ram_ready, in, 1, one-cycle pulse; ram_data is valid in that cycle.
REQ-012 SHALL have port ram_data, in, INST_WIDTH, fetched instruction.
REQ-013 SHALL have port out_valid, out, 1, queue head is valid.
REQ-014 SHALL have port out_ready, in, 1, downstream accepts the head.
REQ-015 SHALL have port pc_o, out, ADDR_WIDTH, PC of the head entry.
REQ-016 SHALL have port inst_o, out, INST_WIDTH, instruction of the head entry.
REQ-017 SHALL have port stall_if, out, 1, equal to !out_valid.

Function
REQ-018 SHALL hold fetch_pc, a FIFO of DEPTH {pc, inst} entries, a count of 0..DEPTH, and FSM state IDLE, REQ or DROP.
REQ-019 SHALL drive ram_read=1 exactly in REQ and DROP; ram_addr SHALL be the registered request address and stay stable while ram_read=1 and ram_ready=0.
REQ-020 SHALL move IDLE->REQ when count<DEPTH and jump=0; request address = fetch_pc.
REQ-021 SHALL, in REQ with ram_ready=1 and jump=0, push {ram_addr, ram_data} and set fetch_pc += 4 (modulo 2^ADDR_WIDTH).
- Next state: REQ at the new fetch_pc if post-update count<DEPTH, else IDLE.
REQ-022 SHALL allow at most one outstanding request; a new request is issued only after ram_ready is seen.
REQ-023 SHALL pop the head when out_valid && out_ready; push and pop in the same cycle leave count unchanged.
REQ-024 SHALL drive pc_o and inst_o to 0 when out_valid=0.
REQ-025 SHALL, on jump=1, do all of the following:
- empty the FIFO (count=0); any same-cycle pop or push is discarded;
- set fetch_pc = jump_addr;
- if in IDLE, or in REQ/DROP with ram_ready=1: go to REQ at jump_addr next cycle;
- if in REQ/DROP with ram_ready=0: go to DROP, keeping ram_read=1 and the old ram_addr.
REQ-026 SHALL, in DROP with ram_ready=1 and jump=0, discard ram_data and go to REQ at fetch_pc.
REQ-027 SHALL give 2-cycle minimum latency from request issue to out_valid: the ram_ready cycle, then the registered FIFO head.
REQ-028 SHALL never push when count==DEPTH; this is guaranteed by the issue rule in REQ-020/021.

Reset
REQ-029 SHALL, while reset=1, force state=IDLE, count=0, fetch_pc=RESET_PC, ram_read=0, ram_addr=0, out_valid=0, pc_o=0, inst_o=0, stall_if=1.
- ram_ready is ignored during reset, including mid-request.
REQ-030 SHALL, in the first cycle after reset deasserts, leave IDLE; ram_read=1 with ram_addr=RESET_PC follows on the next cycle.

Verification
REQ-031 SHALL cover sequential fetch.
- Stimulus: ram_ready one cycle after each request; out_ready=1.
- Response: pc_o sequence 0,4,8,12 with matching inst_o; stall_if=0 once streaming.
REQ-032 SHALL cover queue full.
- Stimulus: DEPTH=4, out_ready=0.
- Response: exactly 4 pushes, then ram_read=0 and state IDLE.
- Then raise out_ready for 1 cycle: one pop and one new request at 0x10.
REQ-033 SHALL cover jump during an outstanding request.
- Stimulus: jump=1, jump_addr=0x100, ram_ready delayed 3 cycles.
- Response: ram_addr holds the old value until ram_ready; that data is dropped; next ram_addr=0x100; first pc_o=0x100.
REQ-034 SHALL cover jump coinciding with ram_ready and pop.
- Response: no push occurs; count=0; next ram_addr=jump_addr.
REQ-035 SHALL cover reset mid-request.
- Stimulus: reset asserted while ram_read=1.
- Response: next cycle all outputs per REQ-029; the later fetch restarts at RESET_PC.
REQ-036 SHALL cover PC wrap-around.
- Stimulus: jump_addr=0xFFFFFFFC.
- Response: pc_o sequence 0xFFFFFFFC, then 0x00000000.
